interrupt_ctrl: RTL and testbench
=================================

// Module: interrupt_ctrl
// PURPOSE
//  CPU-side responder for the three external interrupt lines (inter1..3).
//  Captures one-cycle request pulses and arbitrates by fixed priority (3 highest).
//  Supports nesting: a higher level pre-empts a lower one. Issues a PC redirect
//  to the CPU, keeps one EPC per level and drives the inter_running indicators.
//  Sits between the top-level interrupt pins and the datapath PC-select/ERET logic.
// PARAMETERS
//  NUM_SRC     3             number of interrupt levels; bit i = level i+1, MSB highest
//  VEC_BASE    32'h0000_0100 handler address of level 1
//  VEC_STRIDE  32'h0000_0040 address gap between consecutive level handlers
// PORTS
//  clk            in   1        system clock, rising edge
//  clr_n          in   1        reset, synchronous, active-low
//  inter_req      in   NUM_SRC  raw request lines (inter1..3); pulses of >=1 cycle
//  ie             in   1        global interrupt enable
//  stall          in   1        CPU cannot accept a redirect this cycle
//  pc_next        in   32       resume address, saved as EPC when an interrupt is taken
//  eret           in   1        one-cycle pulse: current handler returns
//  int_take       out  1        one-cycle pulse: CPU loads int_vector into PC
//  int_vector     out  32       handler address, valid while int_take=1
//  epc            out  32       return address of the highest in-service level
//  inter_running  out  NUM_SRC  in-service mask (nested levels stay set)
//  pending        out  NUM_SRC  latched, not-yet-serviced requests
// BEHAVIOUR
//  Reset (clr_n=0 at an edge):
//   - pending, inter_running, int_take, int_vector, epc, all EPC slots and edge regs -> 0.
//   - Reset mid-handler drops all state; no take occurs in the cycle after release.
//  Capture:
//   - Rising edge of inter_req[i], against the previous-cycle sample, sets pending[i] at that edge.
//   - A level held high sets pending once only.
//  Arbitration (combinational, all from registers):
//   - cur  = index+1 of highest set inter_running bit (0 if none).
//   - cand = index+1 of highest set pending bit (0 if none).
//   - go   = ie & ~stall & ~eret & ~int_take & (cand > cur).
//  Take (edge where go=1):
//   - int_take<=1 for exactly one cycle.
//   - int_vector<=VEC_BASE+(cand-1)*VEC_STRIDE.
//   - pending[cand-1]<=0; inter_running[cand-1]<=1; epc_slot[cand-1]<=pc_next.
//   - A new rising edge on the same line at that edge re-sets pending (set wins).
//  Latency:
//   - Request edge sampled at E0 -> int_take high in the cycle after E1 (E1 = E0+1),
//     provided go=1 during cycle E0..E1.
//   - Two takes are always separated by >=1 idle cycle.
//  Return:
//   - eret with cur>0 clears inter_running[cur-1] at the edge.
//   - eret has priority over take in the same cycle; the take is re-evaluated next cycle.
//   - eret with cur=0 is ignored.
//  EPC and status:
//   - epc = epc_slot[cur-1] when cur>0, else 0; combinational from registers.
//   - Lower-level requests arriving during a higher handler stay pending and are
//     taken only after cur drops below them.
//   - ie=0 or stall=1: requests accumulate in pending; nothing is lost or dropped.
//  Width/arith: vector math 32-bit unsigned, wrap ignored (params chosen in range).
// STRUCTURE
//  Shared package: NUM_SRC, VEC_BASE, VEC_STRIDE, level encoding (0=none, 1..NUM_SRC).
//  Sub-module int_prio_enc: NUM_SRC mask -> highest level index.
//   - Instantiated twice, once for cur and once for cand.
//  Remainder: edge regs, pending/in-service regs, EPC slot array, output regs.
// TESTING
//  1 Single: reset 2 cyc; ie=1, pc_next=0x40; pulse inter_req=001 for 1 cyc.
//    -> int_take one cycle, 2 cyc after sample; int_vector=0x100; inter_running=001; epc=0x40.
//    -> eret -> inter_running=000, epc=0.
//  2 Nest 1->2->3: pulse 001 (pc 0x40), 010 (pc 0x80), 100 (pc 0xC0), spaced 20 cyc.
//    -> vectors 0x100/0x140/0x180; inter_running 001->011->111.
//    -> 3x eret: 111->011->001->000, with epc 0xC0->0x80->0x40->0.
//  3 Low during high: level 3 running; pulse 001.
//    -> no take; pending=001. eret -> level 1 taken within 2 cyc.
//  4 Simultaneous 101 pulse -> level 3 taken first, pending=001; level 1 taken after eret.
//  5 Gating: ie=0 (or stall=1) while pulsing 010 -> pending=010, no take.
//    -> ie=1 -> int_take in the following cycle.
//  6 Reset mid-ISR: inter_running=011, pending=100; clr_n=0 one edge.
//    -> all outputs 0; later eret ignored; no spurious int_take.

Source files
------------

// File: rtl/interrupt_ctrl_pkg.sv
// Shared constants and level encoding for the external interrupt controller.
// A level is 0 for "none", otherwise index+1 of the interrupt line.
package interrupt_ctrl_pkg;

    localparam int unsigned NUM_SRC    = 3;
    localparam logic [31:0] VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0] VEC_STRIDE = 32'h0000_0040;
    localparam int unsigned LVL_W      = $clog2(NUM_SRC + 1);

    typedef logic [LVL_W-1:0] level_t;

    localparam level_t LVL_NONE = '0;

    function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] lvl);
        return base + (lvl - 32'd1) * stride;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: returns index+1 of the highest set mask bit, 0 if none.
module int_prio_enc
    import interrupt_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = interrupt_ctrl_pkg::NUM_SRC,
    parameter int unsigned LVL_W   = interrupt_ctrl_pkg::LVL_W
) (
    input  logic [NUM_SRC-1:0] mask_i,
    output logic [LVL_W-1:0]   level_o
);

    always_comb begin
        level_o = LVL_W'(LVL_NONE);
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (mask_i[i]) begin
                level_o = LVL_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// Nested fixed-priority interrupt responder: captures request edges, redirects
// the PC to the level handler, and keeps one return address per level.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC    = interrupt_ctrl_pkg::NUM_SRC,
    parameter logic [31:0] VEC_BASE   = interrupt_ctrl_pkg::VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = interrupt_ctrl_pkg::VEC_STRIDE
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [NUM_SRC-1:0] inter_req,
    input  logic               ie,
    input  logic               stall,
    input  logic [31:0]        pc_next,
    input  logic               eret,
    output logic               int_take,
    output logic [31:0]        int_vector,
    output logic [31:0]        epc,
    output logic [NUM_SRC-1:0] inter_running,
    output logic [NUM_SRC-1:0] pending
);

    localparam int unsigned LW = $clog2(NUM_SRC + 1);
    localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] running_q, running_d;
    logic               take_q, take_d;
    logic [31:0]        vector_q, vector_d;
    logic [31:0]        slot_q [NUM_SRC];

    logic [LW-1:0]      cur, cand;
    logic [IW-1:0]      cur_idx, cand_idx;
    logic [NUM_SRC-1:0] rise;
    logic               go;

    int_prio_enc #(.NUM_SRC(NUM_SRC), .LVL_W(LW)) u_cur_enc (
        .mask_i  (running_q),
        .level_o (cur)
    );

    int_prio_enc #(.NUM_SRC(NUM_SRC), .LVL_W(LW)) u_cand_enc (
        .mask_i  (pending_q),
        .level_o (cand)
    );

    always_comb begin
        rise     = inter_req & ~req_q;
        cur_idx  = IW'(cur - LW'(1));
        cand_idx = IW'(cand - LW'(1));
        // eret and the cycle right after a take both block arbitration
        go = ie & ~stall & ~eret & ~take_q & (cand > cur);

        epc = (cur != '0) ? slot_q[cur_idx] : '0;

        // A fresh edge on the line being taken keeps it pending
        pending_d = pending_q;
        if (go) begin
            pending_d[cand_idx] = 1'b0;
        end
        pending_d = pending_d | rise;

        running_d = running_q;
        if (eret && (cur != '0)) begin
            running_d[cur_idx] = 1'b0;
        end
        if (go) begin
            running_d[cand_idx] = 1'b1;
        end

        take_d   = go;
        vector_d = go ? vec_addr(VEC_BASE, VEC_STRIDE, 32'(cand)) : '0;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            req_q     <= '0;
            pending_q <= '0;
            running_q <= '0;
            take_q    <= 1'b0;
            vector_q  <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            req_q     <= inter_req;
            pending_q <= pending_d;
            running_q <= running_d;
            take_q    <= take_d;
            vector_q  <= vector_d;
            if (go) begin
                slot_q[cand_idx] <= pc_next;
            end
        end
    end

    assign int_take      = take_q;
    assign int_vector    = vector_q;
    assign inter_running = running_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: single take, nesting, masking of lower
// levels, simultaneous requests, gating, same-line re-request and reset mid-handler.
module tb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [2:0]  inter_req;
    logic        ie;
    logic        stall;
    logic [31:0] pc_next;
    logic        eret;
    logic        int_take;
    logic [31:0] int_vector;
    logic [31:0] epc;
    logic [2:0]  inter_running;
    logic [2:0]  pending;

    int tests = 0;
    int fails = 0;

    interrupt_ctrl dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .inter_req     (inter_req),
        .ie            (ie),
        .stall         (stall),
        .pc_next       (pc_next),
        .eret          (eret),
        .int_take      (int_take),
        .int_vector    (int_vector),
        .epc           (epc),
        .inter_running (inter_running),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive req for one sampling edge, then drop it
    task automatic pulse(input logic [2:0] req);
        inter_req = req;
        tick();
        inter_req = 3'b000;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    // Called right after the request edge: take must appear after the next edge
    task automatic expect_take(input string tag, input logic [31:0] vec,
                               input logic [2:0] run, input logic [31:0] e);
        tick();
        chk({tag, "_take"}, 32'(int_take), 32'd1);
        chk({tag, "_vec"}, int_vector, vec);
        chk({tag, "_run"}, 32'(inter_running), 32'(run));
        chk({tag, "_epc"}, epc, e);
        tick();
        chk({tag, "_take_1cyc"}, 32'(int_take), 32'd0);
    endtask

    initial begin
        clr_n = 1'b0; inter_req = '0; ie = 1'b0; stall = 1'b0;
        pc_next = '0; eret = 1'b0;
        tick(); tick();
        chk("rst_take", 32'(int_take), 32'd0);
        chk("rst_vec", int_vector, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_run", 32'(inter_running), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        clr_n = 1'b1; ie = 1'b1; pc_next = 32'h40;
        tick();

        // Single request
        pulse(3'b001);
        chk("s1_pend", 32'(pending), 32'b001);
        chk("s1_notake_yet", 32'(int_take), 32'd0);
        expect_take("s1", 32'h100, 3'b001, 32'h40);
        chk("s1_pend_clr", 32'(pending), 32'd0);
        do_eret();
        chk("s1_eret_run", 32'(inter_running), 32'd0);
        chk("s1_eret_epc", epc, 32'd0);
        do_eret();
        chk("s1_eret_idle_run", 32'(inter_running), 32'd0);
        chk("s1_eret_idle_take", 32'(int_take), 32'd0);

        // Held level only sets pending once
        inter_req = 3'b010;
        tick();
        expect_take("held", 32'h140, 3'b010, 32'h40);
        repeat (3) tick();
        chk("held_pend", 32'(pending), 32'd0);
        chk("held_notake", 32'(int_take), 32'd0);
        inter_req = 3'b000;
        do_eret();

        // Nesting 1 -> 2 -> 3
        repeat (5) tick();
        pc_next = 32'h40; pulse(3'b001);
        expect_take("n1", 32'h100, 3'b001, 32'h40);
        repeat (5) tick();
        pc_next = 32'h80; pulse(3'b010);
        expect_take("n2", 32'h140, 3'b011, 32'h80);
        repeat (5) tick();
        pc_next = 32'hC0; pulse(3'b100);
        expect_take("n3", 32'h180, 3'b111, 32'hC0);
        do_eret();
        chk("n_eret3_run", 32'(inter_running), 32'b011);
        chk("n_eret3_epc", epc, 32'h80);
        do_eret();
        chk("n_eret2_run", 32'(inter_running), 32'b001);
        chk("n_eret2_epc", epc, 32'h40);
        do_eret();
        chk("n_eret1_run", 32'(inter_running), 32'b000);
        chk("n_eret1_epc", epc, 32'h0);

        // Low-priority request while level 3 runs
        pc_next = 32'h100; pulse(3'b100);
        expect_take("l3", 32'h180, 3'b100, 32'h100);
        pc_next = 32'h200; pulse(3'b001);
        chk("low_pend", 32'(pending), 32'b001);
        repeat (3) tick();
        chk("low_notake", 32'(int_take), 32'd0);
        chk("low_pend_kept", 32'(pending), 32'b001);
        do_eret();
        chk("low_eret_take", 32'(int_take), 32'd0);
        chk("low_eret_run", 32'(inter_running), 32'd0);
        tick();
        chk("low_take", 32'(int_take), 32'd1);
        chk("low_vec", int_vector, 32'h100);
        chk("low_epc", epc, 32'h200);
        tick();
        do_eret();

        // Simultaneous levels 1 and 3
        pc_next = 32'h300; pulse(3'b101);
        expect_take("sim3", 32'h180, 3'b100, 32'h300);
        chk("sim_pend", 32'(pending), 32'b001);
        do_eret();
        expect_take("sim1", 32'h100, 3'b001, 32'h300);
        do_eret();

        // Gating by ie and stall
        ie = 1'b0; pulse(3'b010);
        chk("gate_pend", 32'(pending), 32'b010);
        tick(); tick();
        chk("gate_ie_notake", 32'(int_take), 32'd0);
        ie = 1'b1; stall = 1'b1;
        tick(); tick();
        chk("gate_stall_notake", 32'(int_take), 32'd0);
        chk("gate_stall_pend", 32'(pending), 32'b010);
        pc_next = 32'h400; stall = 1'b0;
        tick();
        chk("gate_take", 32'(int_take), 32'd1);
        chk("gate_vec", int_vector, 32'h140);
        chk("gate_epc", epc, 32'h400);
        tick();
        do_eret();

        // New edge on the line being taken re-sets its pending bit
        ie = 1'b0; pulse(3'b001);
        tick();
        ie = 1'b1; inter_req = 3'b001;
        tick();
        inter_req = 3'b000;
        chk("setwins_take", 32'(int_take), 32'd1);
        chk("setwins_pend", 32'(pending), 32'b001);
        chk("setwins_run", 32'(inter_running), 32'b001);
        tick();
        chk("setwins_notake", 32'(int_take), 32'd0);
        do_eret();
        tick();
        chk("setwins_retake", 32'(int_take), 32'd1);
        tick();
        do_eret();

        // Reset mid-handler
        pc_next = 32'h500; pulse(3'b001);
        expect_take("r1", 32'h100, 3'b001, 32'h500);
        pc_next = 32'h600; pulse(3'b010);
        expect_take("r2", 32'h140, 3'b011, 32'h600);
        ie = 1'b0; pulse(3'b100);
        chk("r_pend", 32'(pending), 32'b100);
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1; ie = 1'b1;
        chk("r_run", 32'(inter_running), 32'd0);
        chk("r_pend0", 32'(pending), 32'd0);
        chk("r_epc", epc, 32'd0);
        chk("r_take", 32'(int_take), 32'd0);
        chk("r_vec", int_vector, 32'd0);
        tick();
        chk("r_after_take", 32'(int_take), 32'd0);
        do_eret();
        chk("r_eret_run", 32'(inter_running), 32'd0);
        chk("r_eret_epc", epc, 32'd0);
        tick();
        chk("r_eret_take", 32'(int_take), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
